// File: rtl/traffic_light_pkg.sv
// Shared types for the traffic-light safety monitor: lamp encoding, fault codes,
// monitor states, default timing parameters and a lowest-lane priority helper.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        RED     = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10,
        INVALID = 2'b11
    } light_t;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_INVALID      = 3'd1,
        FC_CONFLICT     = 3'd2,
        FC_SEQUENCE     = 3'd3,
        FC_SHORT_YELLOW = 3'd4,
        FC_WATCHDOG     = 3'd5
    } fault_code_t;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        FAULT   = 2'd1,
        RECOVER = 2'd2
    } mon_state_t;

    localparam int DEF_MIN_YELLOW  = 2;
    localparam int DEF_MAX_GREEN   = 64;
    localparam int DEF_RECOVER_CYC = 4;
    localparam int CNT_W           = $clog2(DEF_MAX_GREEN + 1);

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        if (v[0]) begin
            return 2'd0;
        end else if (v[1]) begin
            return 2'd1;
        end else if (v[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

endpackage

// File: rtl/tlc_lane_check.sv
// Per-lane rule checks: compares the live lane code against its registered copy
// and the shared phase counter, flagging each class of unsafe behaviour.
module tlc_lane_check
    import traffic_light_pkg::*;
#(
    parameter int MIN_YELLOW = DEF_MIN_YELLOW,
    parameter int MAX_GREEN  = DEF_MAX_GREEN,
    parameter int CNT_W      = traffic_light_pkg::CNT_W
) (
    input  logic [1:0]       cur,
    input  logic [1:0]       prev,
    input  logic [CNT_W-1:0] phase_cnt,
    output logic             invalid,
    output logic             seq_err,
    output logic             short_yel,
    output logic             wdog,
    output logic             nonred
);
    localparam logic [CNT_W-1:0] MIN_Y_C = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_G_C = CNT_W'(MAX_GREEN);

    assign invalid   = (cur == INVALID);
    assign nonred    = (cur != RED);
    assign seq_err   = ((prev == RED)    && (cur == YELLOW)) ||
                       ((prev == YELLOW) && (cur == GREEN))  ||
                       ((prev == GREEN)  && (cur == RED));
    assign short_yel = (prev == YELLOW) && (cur == RED) && (phase_cnt < MIN_Y_C);
    // phase_cnt saturates, so equality holds for every cycle past the limit
    assign wdog      = (prev == GREEN) && (cur == GREEN) && (phase_cnt == MAX_G_C);

endmodule

// File: rtl/traffic_light_safety_monitor.sv
// Safety monitor between the light controller and the lamps: passes legal patterns
// through with one cycle of latency and forces all-RED on any unsafe pattern.
module traffic_light_safety_monitor
    import traffic_light_pkg::*;
#(
    parameter int MIN_YELLOW  = DEF_MIN_YELLOW,
    parameter int MAX_GREEN   = DEF_MAX_GREEN,
    parameter int RECOVER_CYC = DEF_RECOVER_CYC
) (
    input  logic       clk11,
    input  logic       rst_n11,
    input  logic [1:0] in01,
    input  logic [1:0] in11,
    input  logic [1:0] in21,
    input  logic [1:0] in31,
    input  logic       fault_clr,
    output logic [1:0] lamp01,
    output logic [1:0] lamp11,
    output logic [1:0] lamp21,
    output logic [1:0] lamp31,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_lane
);
    localparam int CW = $clog2(MAX_GREEN + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_GREEN);
    localparam logic [CW-1:0] REC_C = CW'(RECOVER_CYC);

    logic [3:0][1:0] cur_s, in_q_r, lamps_r, lamps_s;
    logic [CW-1:0]   phase_cnt_r, rec_cnt_r, rec_cnt_s;
    logic [3:0]      invalid_s, seq_err_s, short_yel_s, wdog_s, nonred_s;
    mon_state_t      state_r, state_s;
    fault_code_t     code_r, code_s, det_code_s;
    logic [1:0]      lane_r, lane_s, det_lane_s;
    logic            fault_r, fault_s, all_red_s;

    assign cur_s     = {in31, in21, in11, in01};
    assign all_red_s = (cur_s == 8'h00);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        tlc_lane_check #(
            .MIN_YELLOW (MIN_YELLOW),
            .MAX_GREEN  (MAX_GREEN),
            .CNT_W      (CW)
        ) u_chk (
            .cur       (cur_s[i]),
            .prev      (in_q_r[i]),
            .phase_cnt (phase_cnt_r),
            .invalid   (invalid_s[i]),
            .seq_err   (seq_err_s[i]),
            .short_yel (short_yel_s[i]),
            .wdog      (wdog_s[i]),
            .nonred    (nonred_s[i])
        );
    end

    // Fault priority encoder: highest-priority class first, lowest lane within a class
    always_comb begin
        det_code_s = FC_NONE;
        det_lane_s = 2'd0;
        if (|invalid_s) begin
            det_code_s = FC_INVALID;
            det_lane_s = lowest_set(invalid_s);
        end else if ((nonred_s & (nonred_s - 4'd1)) != 4'd0) begin
            det_code_s = FC_CONFLICT;
            det_lane_s = lowest_set(nonred_s);
        end else if (|seq_err_s) begin
            det_code_s = FC_SEQUENCE;
            det_lane_s = lowest_set(seq_err_s);
        end else if (|short_yel_s) begin
            det_code_s = FC_SHORT_YELLOW;
            det_lane_s = lowest_set(short_yel_s);
        end else if (|wdog_s) begin
            det_code_s = FC_WATCHDOG;
            det_lane_s = lowest_set(wdog_s);
        end else begin
            det_code_s = FC_NONE;
            det_lane_s = 2'd0;
        end
    end

    // Input history and saturating phase counter, updated in every state
    always_ff @(posedge clk11 or negedge rst_n11) begin
        if (!rst_n11) begin
            in_q_r      <= 8'h00;
            phase_cnt_r <= '0;
        end else begin
            in_q_r <= cur_s;
            if (cur_s != in_q_r) begin
                phase_cnt_r <= CW'(1);
            end else if (phase_cnt_r != MAX_C) begin
                phase_cnt_r <= phase_cnt_r + CW'(1);
            end else begin
                phase_cnt_r <= phase_cnt_r;
            end
        end
    end

    // Monitor FSM next-state and next-output logic
    always_comb begin
        state_s   = state_r;
        lamps_s   = 8'h00;
        fault_s   = fault_r;
        code_s    = code_r;
        lane_s    = lane_r;
        rec_cnt_s = rec_cnt_r;
        case (state_r)
            MONITOR: begin
                if (det_code_s != FC_NONE) begin
                    state_s = FAULT;
                    fault_s = 1'b1;
                    code_s  = det_code_s;
                    lane_s  = det_lane_s;
                end else begin
                    lamps_s = cur_s;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_s   = RECOVER;
                    rec_cnt_s = '0;
                end else begin
                    state_s = FAULT;
                end
            end
            RECOVER: begin
                if (!all_red_s) begin
                    rec_cnt_s = '0;
                end else if ((rec_cnt_r + CW'(1)) == REC_C) begin
                    state_s   = MONITOR;
                    fault_s   = 1'b0;
                    code_s    = FC_NONE;
                    lane_s    = 2'd0;
                    rec_cnt_s = '0;
                end else begin
                    rec_cnt_s = rec_cnt_r + CW'(1);
                end
            end
            default: begin
                // Unreachable encoding: hold the lamps safe and demand a fresh recovery
                state_s   = FAULT;
                fault_s   = 1'b1;
                rec_cnt_s = '0;
            end
        endcase
    end

    // State, counter and registered output drive
    always_ff @(posedge clk11 or negedge rst_n11) begin
        if (!rst_n11) begin
            state_r   <= MONITOR;
            lamps_r   <= 8'h00;
            fault_r   <= 1'b0;
            code_r    <= FC_NONE;
            lane_r    <= 2'd0;
            rec_cnt_r <= '0;
        end else begin
            state_r   <= state_s;
            lamps_r   <= lamps_s;
            fault_r   <= fault_s;
            code_r    <= code_s;
            lane_r    <= lane_s;
            rec_cnt_r <= rec_cnt_s;
        end
    end

    assign lamp01     = lamps_r[0];
    assign lamp11     = lamps_r[1];
    assign lamp21     = lamps_r[2];
    assign lamp31     = lamps_r[3];
    assign fault      = fault_r;
    assign fault_code = code_r;
    assign fault_lane = lane_r;

endmodule

// File: tb/tb_traffic_light_safety_monitor.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected outputs;
// a monitor pops and compares one entry after every clock edge.
module tb_traffic_light_safety_monitor;
    localparam logic [1:0] R = 2'b00, G = 2'b01, Y = 2'b10, X = 2'b11;
    localparam int MINY = 2, MAXG = 64, RECN = 4;

    logic       clk11 = 1'b0;
    logic       rst_n11;
    logic [1:0] in01, in11, in21, in31;
    logic       fault_clr;
    logic [1:0] lamp01, lamp11, lamp21, lamp31;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_lane;

    traffic_light_safety_monitor dut (
        .clk11(clk11), .rst_n11(rst_n11),
        .in01(in01), .in11(in11), .in21(in21), .in31(in31),
        .fault_clr(fault_clr),
        .lamp01(lamp01), .lamp11(lamp11), .lamp21(lamp21), .lamp31(lamp31),
        .fault(fault), .fault_code(fault_code), .fault_lane(fault_lane)
    );

    always #5 clk11 = ~clk11;

    int n_checks = 0;
    int n_pass   = 0;
    logic [13:0] exp_q[$];
    logic [13:0] exp_v;

    // reference model: mode 0 monitoring, 1 faulted, 2 recovering
    logic [1:0] m_prev[4];
    logic [1:0] m_lamp[4];
    int m_run, m_mode, m_code, m_lane, m_rcnt, m_fault;
    logic [1:0] cv[4];

    function automatic logic [13:0] outs_now();
        return {lamp31, lamp21, lamp11, lamp01, fault, fault_code, fault_lane};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: lamps/fault/code/lane got %h expected %h", name, $time, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = R;
            m_lamp[i] = R;
        end
        m_run = 0; m_mode = 0; m_code = 0; m_lane = 0; m_rcnt = 0; m_fault = 0;
    endtask

    function automatic void classify(input logic [1:0] v[4], output int code, output int lane);
        int n, first;
        code = 0; lane = 0; n = 0; first = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i] == X && code == 0) begin code = 1; lane = i; end
            if (v[i] != R) begin n++; if (first < 0) first = i; end
        end
        if (code == 0 && n > 1) begin code = 2; lane = first; end
        for (int i = 0; i < 4; i++)
            if (code == 0 && ((m_prev[i] == R && v[i] == Y) || (m_prev[i] == Y && v[i] == G) ||
                              (m_prev[i] == G && v[i] == R))) begin code = 3; lane = i; end
        for (int i = 0; i < 4; i++)
            if (code == 0 && m_prev[i] == Y && v[i] == R && m_run < MINY) begin code = 4; lane = i; end
        for (int i = 0; i < 4; i++)
            if (code == 0 && m_prev[i] == G && v[i] == G && m_run == MAXG) begin code = 5; lane = i; end
    endfunction

    task automatic drive(input logic [1:0] a, b, c, d, input logic clr);
        logic [1:0] v[4];
        int code, lane;
        bit same, allred;
        @(negedge clk11);
        in01 = a; in11 = b; in21 = c; in31 = d; fault_clr = clr;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        same = 1'b1; allred = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[i] != m_prev[i]) same = 1'b0;
            if (v[i] != R) allred = 1'b0;
        end
        for (int i = 0; i < 4; i++) m_lamp[i] = R;
        if (m_mode == 0) begin
            classify(v, code, lane);
            if (code != 0) begin
                m_mode = 1; m_fault = 1; m_code = code; m_lane = lane;
            end else begin
                for (int i = 0; i < 4; i++) m_lamp[i] = v[i];
            end
        end else if (m_mode == 1) begin
            if (clr) begin m_mode = 2; m_rcnt = 0; end
        end else begin
            if (!allred) m_rcnt = 0;
            else begin
                m_rcnt++;
                if (m_rcnt == RECN) begin
                    m_mode = 0; m_fault = 0; m_code = 0; m_lane = 0; m_rcnt = 0;
                end
            end
        end
        m_run = same ? ((m_run < MAXG) ? m_run + 1 : MAXG) : 1;
        for (int i = 0; i < 4; i++) m_prev[i] = v[i];
        exp_q.push_back({m_lamp[3], m_lamp[2], m_lamp[1], m_lamp[0], 1'(m_fault), 3'(m_code), 2'(m_lane)});
    endtask

    task automatic recover_seq();
        drive(R, R, R, R, 1'b1);
        repeat (RECN + 1) drive(R, R, R, R, 1'b0);
    endtask

    // monitor: one expected entry per clock edge
    always begin
        @(posedge clk11);
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("cycle", outs_now(), exp_v);
        end
    end

    initial begin
        rst_n11 = 1'b0; fault_clr = 1'b0;
        in01 = R; in11 = R; in21 = R; in31 = R;
        model_reset();
        #12;
        check("reset", outs_now(), 14'h0000);
        @(posedge clk11); #2; rst_n11 = 1'b1;

        // legal pass-through and a full lane0/lane1 cycle
        drive(R, R, R, R, 1'b0); drive(R, R, R, R, 1'b0); drive(G, R, R, R, 1'b0);
        repeat (4) drive(G, R, R, R, 1'b0);
        repeat (2) drive(Y, R, R, R, 1'b0);
        drive(R, R, R, R, 1'b0);
        repeat (3) drive(R, G, R, R, 1'b0);
        repeat (2) drive(R, Y, R, R, 1'b0);
        drive(R, R, R, R, 1'b0);
        // conflict, then invalid taking priority over conflict
        drive(G, R, G, R, 1'b0); recover_seq();
        drive(X, R, G, R, 1'b0); recover_seq();
        // sequence error and short yellow
        drive(R, R, R, G, 1'b0); drive(R, R, R, R, 1'b0); recover_seq();
        repeat (2) drive(R, G, R, R, 1'b0);
        drive(R, Y, R, R, 1'b0); drive(R, R, R, R, 1'b0); recover_seq();
        // watchdog, sticky code, fault_clr outside FAULT, recovery restarted by a GREEN
        repeat (70) drive(R, R, G, R, 1'b0);
        drive(G, R, G, R, 1'b0);
        drive(R, R, R, R, 1'b1); repeat (2) drive(R, R, R, R, 1'b0);
        drive(R, G, R, R, 1'b1);
        repeat (RECN + 1) drive(R, R, R, R, 1'b1);
        // asynchronous reset in the middle of a fault
        drive(R, G, R, R, 1'b0); drive(G, G, R, R, 1'b0);
        @(posedge clk11); #3;
        rst_n11 = 1'b0;
        #1;
        check("async_reset", outs_now(), 14'h0000);
        in01 = R; in11 = R; in21 = R; in31 = R; fault_clr = 1'b0;
        model_reset();
        @(posedge clk11); #2; rst_n11 = 1'b1;

        // randomized controller behaviour with occasional corruption
        for (int i = 0; i < 4; i++) cv[i] = R;
        for (int k = 0; k < 600; k++) begin
            int r, ln;
            bit others_red;
            r = $urandom_range(0, 99);
            ln = $urandom_range(0, 3);
            others_red = 1'b1;
            for (int j = 0; j < 4; j++) if (j != ln && cv[j] != R) others_red = 1'b0;
            if (m_mode != 0 && r < 70) begin
                for (int j = 0; j < 4; j++) cv[j] = R;
            end else if (r >= 50 && r < 88) begin
                case (cv[ln])
                    G:       cv[ln] = Y;
                    Y:       cv[ln] = R;
                    X:       cv[ln] = R;
                    default: cv[ln] = others_red ? G : R;
                endcase
            end else if (r >= 88) begin
                cv[ln] = 2'($urandom_range(0, 3));
            end
            drive(cv[0], cv[1], cv[2], cv[3], $urandom_range(0, 7) == 0);
        end

        repeat (2) @(posedge clk11);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
